// File: rtl/rc5_arb.sv
// rtl/rc5_arb.sv - two-requester round-robin front end for an RC5 cipher core
//
// Accepts one job at a time from one of two requesters. A requester's key is
// reloaded into the core only when it differs from the key that is already
// loaded. The job is run on the core and the result is returned to the
// requester that issued it.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   req_valid/req_ready[1:0]  per-requester request handshake (ready only in IDLE)
//   req_op[1:0]               per-requester op: 0 = encrypt, 1 = decrypt
//   req_data0/1, req_key0/1,
//   req_rounds0/1             per-requester operands
//   resp_valid/resp_ready     per-requester response handshake
//   resp_data, resp_err       shared result word and timeout flag
//   core_load_key             one-cycle key-load pulse to the core
//   core_start_encrypt/decrypt one-cycle start pulses
//   core_key, core_num_rounds,
//   core_d_in                 operands of the current job
//   core_key_ready, core_d_out,
//   core_done                 core status and result
module rc5_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_op,
    input  logic [31:0]  req_data0,
    input  logic [31:0]  req_data1,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_key1,
    input  logic [4:0]   req_rounds0,
    input  logic [4:0]   req_rounds1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [31:0]  resp_data,
    output logic         resp_err,
    output logic         core_load_key,
    output logic         core_start_encrypt,
    output logic         core_start_decrypt,
    output logic [127:0] core_key,
    output logic [4:0]   core_num_rounds,
    output logic [31:0]  core_d_in,
    input  logic         core_key_ready,
    input  logic [31:0]  core_d_out,
    input  logic         core_done
);

    // Wait counter is at least 8 bits, wider if TIMEOUT needs it.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KWAIT,
        START,
        RUN,
        RESP
    } state_t;

    state_t         state_q;
    logic           rr_q;           // requester that wins the next tie
    logic           idx_q;
    logic           op_q;
    logic [127:0]   key_q;
    logic [4:0]     rounds_q;
    logic [31:0]    din_q;
    logic           key_loaded_q;
    logic [127:0]   last_key_q;
    logic [4:0]     last_rounds_q;
    logic [CW-1:0]  cnt_q;
    logic           load_key_q;
    logic           start_enc_q;
    logic           start_dec_q;
    logic [1:0]     resp_valid_q;
    logic [31:0]    resp_data_q;
    logic           resp_err_q;

    logic [1:0]     grant_d;
    logic           accept_d;
    logic           gidx_d;
    logic           sel_op_d;
    logic [31:0]    sel_data_d;
    logic [127:0]   sel_key_d;
    logic [4:0]     sel_rounds_d;
    logic           key_hit_d;
    logic [CW-1:0]  cnt_inc_d;

    // Grant is combinational so the chosen requester sees ready in the same
    // IDLE cycle; it is masked during reset so nothing transfers then.
    always_comb begin
        grant_d = 2'b00;
        if (state_q == IDLE && rst) begin
            case (req_valid)
                2'b01:   grant_d = 2'b01;
                2'b10:   grant_d = 2'b10;
                2'b11:   grant_d = rr_q ? 2'b10 : 2'b01;
                default: grant_d = 2'b00;
            endcase
        end
    end

    assign req_ready    = grant_d;
    assign accept_d     = |(req_valid & grant_d);
    assign gidx_d       = grant_d[1];
    assign sel_op_d     = gidx_d ? req_op[1]   : req_op[0];
    assign sel_data_d   = gidx_d ? req_data1   : req_data0;
    assign sel_key_d    = gidx_d ? req_key1    : req_key0;
    assign sel_rounds_d = gidx_d ? req_rounds1 : req_rounds0;
    assign key_hit_d    = key_loaded_q && (sel_key_d == last_key_q)
                          && (sel_rounds_d == last_rounds_q);
    assign cnt_inc_d    = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_q          <= 1'b0;
            idx_q         <= 1'b0;
            op_q          <= 1'b0;
            key_q         <= '0;
            rounds_q      <= '0;
            din_q         <= '0;
            key_loaded_q  <= 1'b0;
            last_key_q    <= '0;
            last_rounds_q <= '0;
            cnt_q         <= '0;
            load_key_q    <= 1'b0;
            start_enc_q   <= 1'b0;
            start_dec_q   <= 1'b0;
            resp_valid_q  <= 2'b00;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            // Core strobes are single-cycle; they are set only on the
            // transition into the state that owns them.
            load_key_q  <= 1'b0;
            start_enc_q <= 1'b0;
            start_dec_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        idx_q    <= gidx_d;
                        op_q     <= sel_op_d;
                        key_q    <= sel_key_d;
                        rounds_q <= sel_rounds_d;
                        din_q    <= sel_data_d;
                        rr_q     <= ~gidx_d;
                        if (key_hit_d) begin
                            state_q     <= START;
                            start_enc_q <= ~sel_op_d;
                            start_dec_q <= sel_op_d;
                        end else begin
                            state_q    <= LOAD;
                            load_key_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_q <= KWAIT;
                    cnt_q   <= '0;
                end
                KWAIT: begin
                    cnt_q <= cnt_inc_d;
                    // First cycle is skipped: key_ready may still reflect the
                    // previous key before the core reacts to the load pulse.
                    if (cnt_q != '0 && core_key_ready) begin
                        key_loaded_q  <= 1'b1;
                        last_key_q    <= key_q;
                        last_rounds_q <= rounds_q;
                        state_q       <= START;
                        start_enc_q   <= ~op_q;
                        start_dec_q   <= op_q;
                    end else if (cnt_inc_d == TMO) begin
                        key_loaded_q <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= idx_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end
                end
                START: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
                RUN: begin
                    cnt_q <= cnt_inc_d;
                    if (cnt_q != '0 && core_done) begin
                        resp_data_q  <= core_d_out;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= idx_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end else if (cnt_inc_d == TMO) begin
                        // Core state is unknown after a hang, so force a reload.
                        key_loaded_q <= 1'b0;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= idx_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (|(resp_valid_q & resp_ready)) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid         = resp_valid_q;
    assign resp_data          = resp_data_q;
    assign resp_err           = resp_err_q;
    assign core_load_key      = load_key_q;
    assign core_start_encrypt = start_enc_q;
    assign core_start_decrypt = start_dec_q;
    assign core_key           = key_q;
    assign core_num_rounds    = rounds_q;
    assign core_d_in          = din_q;

endmodule

// File: tb/tb_rc5_arb.sv
// tb/tb_rc5_arb.sv - self-checking bench for rc5_arb
module tb_rc5_arb;

    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [31:0]  req_data0 = '0;
    logic [31:0]  req_data1 = '0;
    logic [127:0] req_key0 = '0;
    logic [127:0] req_key1 = '0;
    logic [4:0]   req_rounds0 = '0;
    logic [4:0]   req_rounds1 = '0;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready = 2'b11;
    logic [31:0]  resp_data;
    logic         resp_err;
    logic         core_load_key;
    logic         core_start_encrypt;
    logic         core_start_decrypt;
    logic [127:0] core_key;
    logic [4:0]   core_num_rounds;
    logic [31:0]  core_d_in;
    logic         core_key_ready = 1'b0;
    logic [31:0]  core_d_out = '0;
    logic         core_done = 1'b0;

    rc5_arb #(.TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_data0          (req_data0),
        .req_data1          (req_data1),
        .req_key0           (req_key0),
        .req_key1           (req_key1),
        .req_rounds0        (req_rounds0),
        .req_rounds1        (req_rounds1),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data),
        .resp_err           (resp_err),
        .core_load_key      (core_load_key),
        .core_start_encrypt (core_start_encrypt),
        .core_start_decrypt (core_start_decrypt),
        .core_key           (core_key),
        .core_num_rounds    (core_num_rounds),
        .core_d_in          (core_d_in),
        .core_key_ready     (core_key_ready),
        .core_d_out         (core_d_out),
        .core_done          (core_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stand-in cipher: a fixed mix of every operand, so a wrong key, rounds,
    // data or op routed to the core shows up in the result word.
    function automatic logic [31:0] cfun(input logic [31:0] d, input logic [127:0] k,
                                         input logic [4:0] r, input logic dec);
        return d ^ k[31:0] ^ k[127:96] ^ {27'd0, r} ^ (dec ? 32'hA5A5_0000 : 32'h0000_5A5A);
    endfunction

    // Core model
    int          klat = 2;
    int          dlat = 1;
    bit          d_en = 1'b1;
    int          kc = 0;
    int          dc = 0;
    logic [31:0] res = '0;

    always @(posedge clk) begin
        if (!rst) begin
            core_key_ready <= 1'b0;
            core_done      <= 1'b0;
            kc             <= 0;
            dc             <= 0;
        end else begin
            if (core_load_key) begin
                core_key_ready <= 1'b0;
                kc             <= klat;
            end else if (kc > 0) begin
                kc <= kc - 1;
                if (kc == 1) core_key_ready <= 1'b1;
            end
            core_done <= 1'b0;
            if (core_start_encrypt || core_start_decrypt) begin
                dc  <= dlat;
                res <= cfun(core_d_in, core_key, core_num_rounds, core_start_decrypt);
            end else if (dc > 0) begin
                dc <= dc - 1;
                if (dc == 1 && d_en) begin
                    core_done  <= 1'b1;
                    core_d_out <= res;
                end
            end
        end
    end

    // Scoreboard and monitors
    typedef struct {
        bit          idx;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t pe;
    exp_t ne;
    int   grants[$];
    bit   exp_timeout = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   start_cyc = 0;
    int   rv_cyc = 0;
    bit   prev_rv = 1'b0;
    int   n_load = 0;
    int   n_enc = 0;
    int   n_dec = 0;
    int   inv_bad = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && (req_valid & req_ready) != 2'b00) begin
            ne.idx = req_ready[1];
            if (exp_timeout) begin
                ne.data = 32'h0;
                ne.err  = 1'b1;
            end else if (ne.idx) begin
                ne.data = cfun(req_data1, req_key1, req_rounds1, req_op[1]);
                ne.err  = 1'b0;
            end else begin
                ne.data = cfun(req_data0, req_key0, req_rounds0, req_op[0]);
                ne.err  = 1'b0;
            end
            sb.push_back(ne);
            grants.push_back(int'(ne.idx));
            acc_cyc = cyc;
        end
        if (core_load_key) n_load++;
        if (core_start_encrypt) begin
            n_enc++;
            start_cyc = cyc;
        end
        if (core_start_decrypt) begin
            n_dec++;
            start_cyc = cyc;
        end
        if (resp_valid != 2'b00 && !prev_rv) rv_cyc = cyc;
        prev_rv = (resp_valid != 2'b00);
        if (rst && (resp_valid & resp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {126'd0, resp_valid}, 128'd0);
            end else begin
                pe = sb.pop_front();
                check("resp_idx", {126'd0, resp_valid}, pe.idx ? 128'd2 : 128'd1);
                check("resp_data", {96'd0, resp_data}, {96'd0, pe.data});
                check("resp_err", {127'd0, resp_err}, {127'd0, pe.err});
            end
        end
    end

    always @(negedge clk) begin
        if ($countones(req_ready) > 1 || (core_start_encrypt && core_start_decrypt)
            || $countones(resp_valid) > 1)
            inv_bad++;
    end

    // Stimulus helpers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {req_ready, resp_valid, resp_data, resp_err, core_load_key,
                   core_start_encrypt, core_start_decrypt, core_num_rounds, core_d_in},
              128'd0);
        check({nm, "_key"}, core_key, 128'd0);
    endtask

    task automatic set_req(input int i, input bit op, input logic [31:0] d,
                           input logic [127:0] k, input logic [4:0] r);
        if (i == 0) begin
            req_data0 = d; req_key0 = k; req_rounds0 = r;
        end else begin
            req_data1 = d; req_key1 = k; req_rounds1 = r;
        end
        req_op[i] = op;
    endtask

    task automatic wait_accept(input int i);
        int n;
        n = 0;
        #1;
        while (!req_ready[i] && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_bound", {127'd0, n < 400}, 128'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain"}, {127'd0, n < 400}, 128'd1);
    endtask

    task automatic run_job(input int i, input bit op, input logic [31:0] d,
                           input logic [127:0] k, input logic [4:0] r,
                           input bit exp_load, input string nm);
        int l0, e0, d0;
        l0 = n_load; e0 = n_enc; d0 = n_dec;
        @(negedge clk);
        set_req(i, op, d, k, r);
        req_valid[i] = 1'b1;
        wait_accept(i);
        wait_drain(nm);
        check({nm, "_loads"}, n_load - l0, {127'd0, exp_load});
        check({nm, "_enc"}, n_enc - e0, {127'd0, !op});
        check({nm, "_dec"}, n_dec - d0, {127'd0, op});
        if (!exp_load) check({nm, "_start_lat"}, start_cyc - acc_cyc, 128'd1);
    endtask

    typedef struct {
        int           i;
        bit           op;
        logic [31:0]  d;
        logic [127:0] k;
        logic [4:0]   r;
        bit           load;
        int           kl;
        int           dl;
    } vec_t;

    localparam logic [127:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] K2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [127:0] K3 = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] KF = {128{1'b1}};

    vec_t vecs[9];
    int   l0;
    int   n;
    bit   ok;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h1234_5678, K1, 5'd12, 1'b1, 2, 1};
        vecs[1] = '{0, 1'b0, 32'h0000_0000, K1, 5'd12, 1'b0, 2, 1};
        vecs[2] = '{1, 1'b1, 32'hDEAD_BEEF, K1, 5'd12, 1'b0, 1, 3};
        vecs[3] = '{1, 1'b1, 32'h5555_AAAA, K1, 5'd13, 1'b1, 4, 2};
        vecs[4] = '{0, 1'b0, 32'h0F0F_0F0F, K2, 5'd13, 1'b1, 1, 1};
        vecs[5] = '{0, 1'b1, 32'h8000_0001, K2, 5'd13, 1'b0, 1, 5};
        vecs[6] = '{1, 1'b0, 32'h7FFF_FFFE, K2, 5'd0,  1'b1, 3, 1};
        vecs[7] = '{0, 1'b1, 32'hFFFF_FFFF, KF, 5'd31, 1'b1, 2, 2};
        vecs[8] = '{1, 1'b0, 32'h0000_0000, KF, 5'd31, 1'b0, 2, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b1;

        // Vector table
        for (int v = 0; v < 9; v++) begin
            klat = vecs[v].kl;
            dlat = vecs[v].dl;
            run_job(vecs[v].i, vecs[v].op, vecs[v].d, vecs[v].k, vecs[v].r,
                    vecs[v].load, $sformatf("vec%0d", v));
        end
        klat = 2;
        dlat = 1;

        // Both requesters valid continuously: alternate grants, reload each time
        do_reset();
        set_req(0, 1'b0, 32'hAAAA_0000, K1, 5'd12);
        set_req(1, 1'b1, 32'h0000_BBBB, K2, 5'd12);
        grants.delete();
        l0 = n_load;
        req_valid = 2'b11;
        n = 0;
        while (grants.size() < 4 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 2'b00;
        check("rr_bound", {127'd0, n < 2000}, 128'd1);
        wait_drain("rr");
        for (int g = 0; g < 4; g++)
            check($sformatf("rr_grant%0d", g), (g < grants.size()) ? grants[g] : -1, g % 2);
        check("rr_loads", n_load - l0, 128'd4);

        // Timeout in RUN, then the key must be reloaded
        run_job(0, 1'b0, 32'h1111_2222, K3, 5'd7, 1'b1, "to_pre");
        d_en = 1'b0;
        exp_timeout = 1'b1;
        run_job(0, 1'b0, 32'h3333_4444, K3, 5'd7, 1'b0, "to_job");
        check("to_latency", rv_cyc - start_cyc, TO + 1);
        d_en = 1'b1;
        exp_timeout = 1'b0;
        run_job(0, 1'b1, 32'h5555_6666, K3, 5'd7, 1'b1, "to_post");

        // Response backpressure: held response stays stable, no new grant
        resp_ready = 2'b10;
        @(negedge clk);
        set_req(0, 1'b0, 32'h0BAD_F00D, K1, 5'd12);
        req_valid[0] = 1'b1;
        wait_accept(0);
        n = 0;
        while (!resp_valid[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("bp_bound", {127'd0, n < 400}, 128'd1);
        set_req(1, 1'b1, 32'h0000_0042, K1, 5'd12);
        req_valid[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ok = (resp_valid == 2'b01) && (resp_data == cfun(32'h0BAD_F00D, K1, 5'd12, 1'b0))
                 && (req_ready == 2'b00);
            check("bp_hold", {127'd0, ok}, 128'd1);
        end
        resp_ready = 2'b11;
        wait_accept(1);
        wait_drain("bp");

        // Reset during RUN: job abandoned, next job reloads its key
        d_en = 1'b0;
        l0 = n_enc;
        @(negedge clk);
        set_req(0, 1'b0, 32'h2222_3333, K1, 5'd12);
        req_valid[0] = 1'b1;
        wait_accept(0);
        n = 0;
        while (n_enc == l0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rst_run_bound", {127'd0, n < 400}, 128'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_run");
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        d_en = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_resp", {126'd0, resp_valid}, 128'd0);
        run_job(0, 1'b0, 32'h4444_5555, K1, 5'd12, 1'b1, "rst_post");

        check("invariants", inv_bad, 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc5_arb.md
RC5_ARB -- requirements
Module: rc5_arb

Interface
- REQ-001 SHALL provide parameter TIMEOUT, default 255: maximum cycles spent waiting for core key_ready or done before an error response.
- REQ-002 SHALL provide port clk, input, 1: sole clock, rising edge.
- REQ-003 SHALL provide port rst, input, 1: reset, synchronous, active-low.
- REQ-004 SHALL provide port req_valid, input, 2: per-requester request valid (index 0/1).
- REQ-005 SHALL provide port req_ready, output, 2: per-requester accept; transfer when valid & ready.
- REQ-006 SHALL provide port req_op, input, 2: per-requester op, 0 = encrypt, 1 = decrypt.
- REQ-007 SHALL provide ports req_data0/req_data1 (input, 32 each: data words), req_key0/req_key1 (input, 128 each: keys) and req_rounds0/req_rounds1 (input, 5 each: round counts).
- REQ-008 SHALL provide port resp_valid, output, 2: per-requester response valid.
- REQ-009 SHALL provide port resp_ready, input, 2: per-requester response accept.
- REQ-010 SHALL provide ports resp_data (output, 32: result word) and resp_err (output, 1: response is a timeout error).
- REQ-011 SHALL provide port core_load_key, output, 1: one-cycle key-load pulse to the cipher core.
- REQ-012 SHALL provide ports core_start_encrypt and core_start_decrypt, output, 1 each: one-cycle start pulses.
- REQ-013 SHALL provide ports core_key (output, 128), core_num_rounds (output, 5) and core_d_in (output, 32): core operands.
- REQ-014 SHALL provide ports core_key_ready (input, 1: subkeys valid), core_d_out (input, 32: result) and core_done (input, 1: operation complete).

Function
- REQ-015 SHALL implement FSM states IDLE, LOAD, KWAIT, START, RUN and RESP.
- REQ-016 In IDLE, SHALL assert req_ready for exactly one requester: the sole valid one; if both are valid, the one not granted last (round-robin); none if neither is valid.
- REQ-017 SHALL treat simultaneous requests from both requesters as a round-robin decision; the losing requester's req_valid stays high and is granted next.
- REQ-018 On accept, SHALL capture op, data, key, rounds and the granted index into internal registers, and SHALL hold core_key, core_num_rounds and core_d_in from those registers until the next accept.
- REQ-019 On accept, SHALL go to START if key_loaded = 1 and the captured key and rounds equal the last loaded key and rounds; otherwise SHALL go to LOAD.
- REQ-020 In LOAD, SHALL pulse core_load_key for one cycle, then go to KWAIT.
- REQ-021 In KWAIT, SHALL ignore core_key_ready on the first cycle; on a later cycle with core_key_ready = 1, SHALL set key_loaded = 1, record the key and rounds, and go to START.
- REQ-022 In START, SHALL pulse core_start_encrypt (op = 0) or core_start_decrypt (op = 1) for one cycle, never both, then go to RUN.
- REQ-023 In RUN, SHALL ignore core_done on the first cycle; on a later cycle with core_done = 1, SHALL capture core_d_out into resp_data with resp_err = 0 and go to RESP.
- REQ-024 SHALL run an 8-bit-min wait counter, cleared on entry to KWAIT and to RUN; when it reaches TIMEOUT before the awaited signal, SHALL set resp_data = 0, resp_err = 1, key_loaded = 0, and go to RESP.
- REQ-025 In RESP, SHALL hold resp_valid high only at the captured index until the matching resp_ready = 1, then go to IDLE.
- REQ-026 SHALL update the round-robin pointer on each accept.
- REQ-027 Minimum accept-to-resp_valid latency with the key already loaded SHALL be 3 cycles plus core latency.
- REQ-028 SHALL never assert req_ready outside IDLE and SHALL never assert more than one req_ready bit.

Reset
- REQ-029 While rst = 0 at a clock edge, SHALL enter IDLE and clear key_loaded, the wait counter, all core_* outputs, resp_valid, resp_data and resp_err, and set the round-robin pointer so requester 0 wins the first tie.
- REQ-030 Reset mid-operation SHALL abandon the job with no response, and the next job SHALL reload its key.

Verification
- REQ-031 Scenario: requester 0 encrypts, key K1, 12 rounds, data 0x12345678, after reset -> one core_load_key pulse, then one core_start_encrypt pulse, then resp_valid[0] with resp_data = core_d_out and resp_err = 0.
- REQ-032 Scenario: requester 0 sends a second job with the same K1 and 12 rounds -> no core_load_key pulse; start pulse 1 cycle after accept.
- REQ-033 Scenario: both requesters valid continuously after reset -> grants in order 0, 1, 0, 1; each key change (K1 vs K2) triggers a reload.
- REQ-034 Scenario: core_done held 0 -> resp_err = 1 and resp_data = 0 exactly TIMEOUT cycles after RUN entry; the next job reloads its key.
- REQ-035 Scenario: resp_ready held 0 for 10 cycles -> resp_valid and resp_data stay stable and no req_ready is asserted.
- REQ-036 Scenario: rst = 0 during RUN -> next cycle all outputs are 0, the state is IDLE, and no response is issued.
